// File: rtl/gv_button_conditioner.sv
// gv_button_conditioner: per-button synchronizer, debounce FSM, press/release pulses and
// sticky pending/overrun flags between the raw breakout-board buttons and the core.
module gv_button_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic                   clk,
    input  logic                   gated_reset,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    input  logic [NUM_BUTTONS-1:0] press_ack,
    input  logic                   clear_overrun,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [NUM_BUTTONS-1:0] button_press,
    output logic [NUM_BUTTONS-1:0] button_release,
    output logic [NUM_BUTTONS-1:0] press_pending,
    output logic [NUM_BUTTONS-1:0] press_overrun
);
    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [NUM_BUTTONS-1:0] sync_a_q, sync_b_q;
    logic [NUM_BUTTONS-1:0] press_d, pending_q, pending_d, overrun_q, overrun_d;
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            sync_a_q  <= button_raw;
            sync_b_q  <= sync_a_q;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end
    // A new press outranks a same-cycle ack; overrun judges against the pre-press pending value.
    always_comb begin
        pending_d = press_d | (pending_q & ~press_ack);
        overrun_d = (press_d & pending_q & ~press_ack) | (overrun_q & ~{NUM_BUTTONS{clear_overrun}});
    end
    assign press_pending = pending_q;
    assign press_overrun = overrun_q;
    genvar g;
    generate
        for (g = 0; g < NUM_BUTTONS; g++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d, press_q, release_q, release_d;
            logic             s;
            assign s = sync_b_q[g];
            always_ff @(posedge clk or negedge gated_reset) begin
                if (!gated_reset) begin
                    state_q   <= LOW;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    press_q   <= press_d[g];
                    release_q <= release_d;
                end
            end
            always_comb begin
                state_d    = state_q;
                cnt_d      = cnt_q;
                level_d    = level_q;
                press_d[g] = 1'b0;
                release_d  = 1'b0;
                case (state_q)
                    LOW: begin
                        state_d = s ? WAIT_HIGH : LOW;
                        cnt_d   = s ? CNT_W'(1) : '0;
                    end
                    WAIT_HIGH: begin
                        if (!s) begin
                            state_d = LOW;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d    = HIGH;
                            cnt_d      = '0;
                            level_d    = 1'b1;
                            press_d[g] = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        state_d = s ? HIGH : WAIT_LOW;
                        cnt_d   = s ? '0 : CNT_W'(1);
                    end
                    WAIT_LOW: begin
                        if (s) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d   = LOW;
                            cnt_d     = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                endcase
            end
            assign button_level[g]   = level_q;
            assign button_press[g]   = press_q;
            assign button_release[g] = release_q;
        end
    endgenerate
endmodule
